// File: rtl/pipelined_rca_if.sv
// Streaming bus for pipelined_rca: operand beat in (valid/ready), result beat out (valid/ready).
//   slave  : used by the adder (consumes operands, produces results)
//   master : used by the producer/consumer side (testbench or surrounding datapath)
// Signals: in_valid/in_ready, a, b, cin, sub -> operand side
//          out_valid/out_ready, sum, cout, ovf -> result side
interface pipelined_rca_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor.
// The WIDTH-bit operands are split into STAGES chunks of CHUNK bits; stage k adds
// chunk k plus the carry registered by stage k-1. Latency is STAGES cycles,
// throughput one beat per cycle, global stall when the output is held.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : pipelined_rca_if slave (in_valid/in_ready/a/b/cin/sub, out_valid/out_ready/sum/cout/ovf)
//            in_ready is combinational (= advance); sum/cout/ovf/out_valid are registered.
module pipelined_rca #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pipelined_rca_if.slave bus
);
    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned CW    = CHUNK + 1;
    localparam int unsigned LAST  = STAGES - 1;
    localparam int unsigned MSB   = WIDTH - 1;

    if ((STAGES == 0) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
        $error("pipelined_rca: WIDTH must be a non-zero multiple of STAGES");
    end

    // Per-stage state: valid, skewed operands, partial result, chunk carry-out
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q,   c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              ovf_q, ovf_d;

    logic              advance_c;
    logic [WIDTH-1:0]  src_a, src_b, src_s;
    logic              src_c, src_v;
    logic [CHUNK:0]    chunk_c;

    // Next-state for every stage; stage 0 takes the preprocessed input beat
    always_comb begin
        advance_c = !vld_q[LAST] || bus.out_ready;
        vld_d     = vld_q;
        c_d       = c_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        ovf_d     = ovf_q;
        src_a     = '0;
        src_b     = '0;
        src_s     = '0;
        src_c     = 1'b0;
        src_v     = 1'b0;
        chunk_c   = '0;

        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src_a = bus.a;
                src_b = bus.sub ? ~bus.b : bus.b;
                // sub ? ~cin : cin
                src_c = bus.sub ^ bus.cin;
                src_s = '0;
                src_v = bus.in_valid;
            end else begin
                src_a = a_q[k-1];
                src_b = b_q[k-1];
                src_c = c_q[k-1];
                src_s = s_q[k-1];
                src_v = vld_q[k-1];
            end
            chunk_c = CW'(src_a[k*CHUNK +: CHUNK]) + CW'(src_b[k*CHUNK +: CHUNK]) + CW'(src_c);
            a_d[k]  = src_a;
            b_d[k]  = src_b;
            s_d[k]  = src_s;
            s_d[k][k*CHUNK +: CHUNK] = chunk_c[CHUNK-1:0];
            c_d[k]  = chunk_c[CHUNK];
            vld_d[k] = src_v;
        end

        // Signed overflow from the operand MSBs carried to the final stage
        ovf_d = (a_d[LAST][MSB] == b_d[LAST][MSB]) && (s_d[LAST][MSB] != a_d[LAST][MSB]);
    end

    // Stage registers; the whole pipe (bubbles included) moves only on advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance_c) begin
            vld_q <= vld_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
        end
    end

    assign bus.in_ready  = advance_c;
    assign bus.out_valid = vld_q[LAST];
    assign bus.sum       = s_q[LAST];
    assign bus.cout      = c_q[LAST];
    assign bus.ovf       = ovf_q;
endmodule
